weight_update: RTL and testbench

Sequential weight-update stage for the XOR perceptron. It sits directly downstream of the error stage that produces the delta term `(teach - output) * output * (1 - output)`. It owns the neuron's weight register file and, on each start pulse, applies `w[i] <= w[i] + eta * delta * x[i]` to every weight. All arithmetic is IEEE-754 single precision, using one `fp_multiplier` and one `fp_add_sub` core time-shared under an FSM.

---
 rtl/weight_update.sv | 263 ++++++++++++++++++++++++++
 tb/tb_weight_update.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_update.sv
// Weight-update stage for the XOR perceptron: w[i] <= w[i] + eta*delta*x[i],
// computed with one shared fp32 multiplier and one shared fp32 adder.
// The two cores are simple pipelined fp32 units: normal numbers only,
// truncating rounding, and zero inputs are passed through.

module fp_multiplier #(
  parameter int LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic [47:0] prod_s;
  logic [9:0]  exp_s;
  logic [22:0] frac_s;
  logic        sign_s;
  logic [31:0] res_s;
  logic [31:0] pipe_r [LAT];

  // Combinational fp32 product; the exponent is kept 10 bits wide so a negative value shows up in bit 9.
  always_comb begin
    sign_s = a[31] ^ b[31];
    prod_s = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    if (prod_s[47]) begin
      frac_s = prod_s[46:24];
      exp_s  = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd126;
    end else begin
      frac_s = prod_s[45:23];
      exp_s  = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
      res_s = {sign_s, 31'd0};
    end else if (exp_s[9] || exp_s == 10'd0) begin
      res_s = {sign_s, 31'd0};
    end else if (exp_s >= 10'd255) begin
      res_s = {sign_s, 8'hFF, 23'd0};
    end else begin
      res_s = {sign_s, exp_s[7:0], frac_s};
    end
  end

  // Delay line giving the product a fixed latency of LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe_r[k] <= 32'd0;
    end else begin
      pipe_r[0] <= res_s;
      for (int k = 1; k < LAT; k++) pipe_r[k] <= pipe_r[k-1];
    end
  end

  assign result = pipe_r[LAT-1];
endmodule

module fp_add_sub #(
  parameter int LAT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        add_sub,
  output logic [31:0] result
);
  logic        sb_s, sl_s, a_big_s;
  logic [7:0]  el_s, es_s, diff_s;
  logic [26:0] ml_s, ms_s, ms_sh_s, norm_s;
  logic [27:0] sum_s;
  logic [4:0]  lz_s;
  logic [31:0] res_s;
  logic [31:0] pipe_r [LAT];

  // Align the smaller operand, add or subtract magnitudes, then renormalise.
  always_comb begin
    sb_s    = b[31] ^ ~add_sub;
    a_big_s = (a[30:0] >= b[30:0]);
    if (a_big_s) begin
      sl_s = a[31];
      el_s = a[30:23];
      es_s = b[30:23];
      ml_s = {1'b1, a[22:0], 3'b000};
      ms_s = {1'b1, b[22:0], 3'b000};
    end else begin
      sl_s = sb_s;
      el_s = b[30:23];
      es_s = a[30:23];
      ml_s = {1'b1, b[22:0], 3'b000};
      ms_s = {1'b1, a[22:0], 3'b000};
    end
    diff_s = el_s - es_s;
    if (diff_s > 8'd26) ms_sh_s = 27'd0;
    else                ms_sh_s = ms_s >> diff_s;
    if (a[31] ^ sb_s) sum_s = {1'b0, ml_s} - {1'b0, ms_sh_s};
    else              sum_s = {1'b0, ml_s} + {1'b0, ms_sh_s};
    // Highest set bit wins, giving the leading-zero count below bit 26.
    lz_s = 5'd0;
    for (int k = 0; k < 27; k++) begin
      if (sum_s[k]) lz_s = 5'(26 - k);
      else          lz_s = lz_s;
    end
    norm_s = sum_s[26:0] << lz_s;
    if (a[30:23] == 8'd0) begin
      res_s = {sb_s, b[30:0]};
    end else if (b[30:23] == 8'd0) begin
      res_s = a;
    end else if (sum_s == 28'd0) begin
      res_s = 32'd0;
    end else if (sum_s[27]) begin
      if (el_s == 8'd254) res_s = {sl_s, 8'hFF, 23'd0};
      else                res_s = {sl_s, el_s + 8'd1, sum_s[26:4]};
    end else if ({3'b000, lz_s} >= el_s) begin
      res_s = {sl_s, 31'd0};
    end else begin
      res_s = {sl_s, el_s - {3'b000, lz_s}, norm_s[25:3]};
    end
  end

  // Delay line giving the sum a fixed latency of LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe_r[k] <= 32'd0;
    end else begin
      pipe_r[0] <= res_s;
      for (int k = 1; k < LAT; k++) pipe_r[k] <= pipe_r[k-1];
    end
  end

  assign result = pipe_r[LAT-1];
endmodule

module weight_update #(
  parameter int N_IN     = 3,
  parameter int MULT_LAT = 5,
  parameter int ADD_LAT  = 7
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic [31:0]       iERROR,
  input  logic [31:0]       iETA,
  input  logic [32*N_IN-1:0] iX,
  input  logic              iLOAD,
  input  logic [32*N_IN-1:0] iW_INIT,
  output logic [32*N_IN-1:0] oW,
  output logic              oBUSY,
  output logic              oDONE
);
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

  typedef enum logic [2:0] {S_IDLE, S_ED, S_MUL, S_ADD, S_WR, S_DONE} state_t;

  state_t             state_r, state_s;
  logic [7:0]         cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [31:0]        eta_r, err_r, ed_r, p_r, s_r;
  logic [31:0]        x_r [N_IN];
  logic [31:0]        w_r [N_IN];
  logic [31:0]        mul_a_s, mul_b_s, mul_res_s, add_a_s, add_b_s, add_res_s;
  logic               last_s;

  // Wait-counter reload: hold cycles minus one, so the last cycle sees zero.
  function automatic logic [7:0] hold_len(input state_t st);
    case (st)
      S_ED, S_MUL: hold_len = 8'(MULT_LAT);
      S_ADD:       hold_len = 8'(ADD_LAT);
      default:     hold_len = 8'd0;
    endcase
  endfunction

  assign last_s = (cnt_r == 8'd0);

  fp_multiplier #(.LAT(MULT_LAT)) u_mul (
    .clk(iCLK), .rst(iRST), .a(mul_a_s), .b(mul_b_s), .result(mul_res_s)
  );

  fp_add_sub #(.LAT(ADD_LAT)) u_add (
    .clk(iCLK), .rst(iRST), .a(add_a_s), .b(add_b_s), .add_sub(1'b1), .result(add_res_s)
  );

  // State register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_r <= S_IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic; arithmetic states leave only on their last wait cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: if (!iLOAD && iSTART) state_s = S_ED;   else state_s = S_IDLE;
      S_ED:   if (last_s)           state_s = S_MUL;  else state_s = S_ED;
      S_MUL:  if (last_s)           state_s = S_ADD;  else state_s = S_MUL;
      S_ADD:  if (last_s)           state_s = S_WR;   else state_s = S_ADD;
      S_WR:   if (idx_r == IDX_LAST) state_s = S_DONE; else state_s = S_MUL;
      S_DONE: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Core operand steering; operands depend only on registers so they stay stable per state.
  always_comb begin
    add_a_s = w_r[idx_r];
    add_b_s = p_r;
    if (state_r == S_ED) begin
      mul_a_s = eta_r;
      mul_b_s = err_r;
    end else begin
      mul_a_s = ed_r;
      mul_b_s = x_r[idx_r];
    end
  end

  // Datapath: wait counter, input latches, intermediate captures and weight file.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_r <= 8'd0;
      idx_r <= {IDX_W{1'b0}};
      eta_r <= 32'd0;
      err_r <= 32'd0;
      ed_r  <= 32'd0;
      p_r   <= 32'd0;
      s_r   <= 32'd0;
      for (int k = 0; k < N_IN; k++) begin
        x_r[k] <= 32'd0;
        w_r[k] <= 32'd0;
      end
    end else begin
      if (state_s != state_r)  cnt_r <= hold_len(state_s);
      else if (cnt_r != 8'd0)  cnt_r <= cnt_r - 8'd1;
      else                     cnt_r <= cnt_r;
      case (state_r)
        S_IDLE: begin
          if (iLOAD) begin
            for (int k = 0; k < N_IN; k++) w_r[k] <= iW_INIT[32*k +: 32];
          end else if (iSTART) begin
            eta_r <= iETA;
            err_r <= iERROR;
            idx_r <= {IDX_W{1'b0}};
            for (int k = 0; k < N_IN; k++) x_r[k] <= iX[32*k +: 32];
          end
        end
        S_ED:  if (last_s) ed_r <= mul_res_s;
        S_MUL: if (last_s) p_r  <= mul_res_s;
        S_ADD: if (last_s) s_r  <= add_res_s;
        S_WR: begin
          w_r[idx_r] <= s_r;
          if (idx_r != IDX_LAST) idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_ow
    assign oW[32*g +: 32] = w_r[g];
  end

  assign oBUSY = (state_r != S_IDLE);
  assign oDONE = (state_r == S_DONE);
endmodule

// File: tb/tb_weight_update.sv
// Self-checking bench for weight_update: a vector table of full passes plus
// hand-written timing, back-to-back, latching, priority and reset sequences.
// Expected weights go into a scoreboard at start and are popped on oDONE.
`timescale 1ns/1ps
module tb_weight_update;
  logic        clk = 1'b0;
  logic        iRST, iSTART, iLOAD;
  logic [31:0] iERROR, iETA;
  logic [95:0] iX, iW_INIT, oW;
  logic        oBUSY, oDONE;

  weight_update #(.N_IN(3), .MULT_LAT(5), .ADD_LAT(7)) dut (
    .iCLK(clk), .iRST(iRST), .iSTART(iSTART), .iERROR(iERROR), .iETA(iETA),
    .iX(iX), .iLOAD(iLOAD), .iW_INIT(iW_INIT), .oW(oW), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] w_init;
    logic [31:0] eta;
    logic [31:0] err;
    logic [95:0] x;
    logic [95:0] exp_w;
  } vec_t;

  typedef struct {
    logic [95:0] w;
    int          start_e;
  } exp_t;

  vec_t vecs[5];
  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_err = 0;
  int   edge_cnt = 0, done_seen = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Scoreboard monitor: on each done pulse compare weights and completion cycle.
  always @(negedge clk) begin
    if (oDONE === 1'b1) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got oDONE=1 expected no pass in flight (oW=%h)", oW);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_weights", oW, mon_e.w);
        check("done_cycle", 96'(edge_cnt - mon_e.start_e + 1), 96'd52);
      end
    end
  end

  task automatic load_w(input logic [95:0] w);
    @(negedge clk);
    iW_INIT = w; iLOAD = 1'b1;
    @(posedge clk); #1;
    iLOAD = 1'b0;
    @(negedge clk);
    check("load_latency", oW, w);
  endtask

  task automatic start_pass(input vec_t v, input bit hold);
    exp_t e;
    @(negedge clk);
    iETA = v.eta; iERROR = v.err; iX = v.x; iSTART = 1'b1;
    @(posedge clk); #1;
    e.w = v.exp_w; e.start_e = edge_cnt;
    sb_q.push_back(e);
    if (!hold) iSTART = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_seen;
    for (int c = 0; c < 100 && done_seen == d0; c++) begin
      @(negedge clk); #1;
    end
    if (done_seen == d0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no oDONE in 100 cycles expected one");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   busy_seen, d0;
    exp_t e2;
    // 0.5 * 0.25 * {1,-1,2} added to {0.5,0.5,0}
    vecs[0] = '{96'h00000000_3F000000_3F000000, 32'h3F000000, 32'h3E800000,
                96'h40000000_BF800000_3F800000, 96'h3E800000_3EC00000_3F200000};
    // zero delta leaves weights bit-exact
    vecs[1] = '{96'h00000000_3F000000_3F000000, 32'h3F000000, 32'h00000000,
                96'h40000000_BF800000_3F800000, 96'h00000000_3F000000_3F000000};
    // 1.0*0.5*{1,1,1} added to {1,2,-1} -> {1.5,2.5,-0.5}
    vecs[2] = '{96'hBF800000_40000000_3F800000, 32'h3F800000, 32'h3F000000,
                96'h3F800000_3F800000_3F800000, 96'hBF000000_40200000_3FC00000};
    // negative delta from zero weights -> {-0.125,0.125,-0.25}
    vecs[3] = '{96'h00000000_00000000_00000000, 32'h3F000000, 32'hBE800000,
                96'h40000000_BF800000_3F800000, 96'hBE800000_3E000000_BE000000};
    // exact cancellation and zero input: {0.125,1,3} + 0.125*{-1,4,0} -> {0,1.5,3}
    vecs[4] = '{96'h40400000_3F800000_3E000000, 32'h3F000000, 32'h3E800000,
                96'h00000000_40800000_BF800000, 96'h40400000_3FC00000_00000000};

    iRST = 1'b1; iSTART = 1'b0; iLOAD = 1'b0;
    iERROR = 32'd0; iETA = 32'd0; iX = 96'd0; iW_INIT = 96'd0;
    repeat (3) @(negedge clk);
    check("reset_oW", oW, 96'd0);
    check("reset_busy", 96'(oBUSY), 96'd0);
    check("reset_done", 96'(oDONE), 96'd0);
    iRST = 1'b0;
    @(negedge clk);
    check("release_oW", oW, 96'd0);
    check("release_busy", 96'(oBUSY), 96'd0);

    // Timing of one pass: busy window and done position.
    load_w(vecs[0].w_init);
    start_pass(vecs[0], 1'b0);
    for (int c = 1; c <= 53; c++) begin
      @(negedge clk);
      if (c == 1)  check("busy_cycle1", 96'(oBUSY), 96'd1);
      if (c == 51) check("done_cycle51", 96'(oDONE), 96'd0);
      if (c == 52) begin
        check("busy_cycle52", 96'(oBUSY), 96'd1);
        check("done_cycle52", 96'(oDONE), 96'd1);
      end
      if (c == 53) begin
        check("busy_cycle53", 96'(oBUSY), 96'd0);
        check("done_cycle53", 96'(oDONE), 96'd0);
      end
    end

    // Vector table.
    for (int i = 0; i < 5; i++) begin
      load_w(vecs[i].w_init);
      start_pass(vecs[i], 1'b0);
      wait_done();
    end

    // Back-to-back passes with iSTART held high.
    load_w(vecs[0].w_init);
    start_pass(vecs[0], 1'b1);
    e2.w = 96'h3F000000_3E800000_3F400000;
    e2.start_e = sb_q[sb_q.size()-1].start_e + 53;
    sb_q.push_back(e2);
    wait_done();
    @(negedge clk);
    check("b2b_idle_gap", 96'(oBUSY), 96'd0);
    @(posedge clk); #1;
    iSTART = 1'b0;
    @(negedge clk);
    check("b2b_second_busy", 96'(oBUSY), 96'd1);
    wait_done();

    // Inputs changed at cycle 3 must not affect the pass.
    load_w(vecs[0].w_init);
    start_pass(vecs[0], 1'b0);
    repeat (3) @(negedge clk);
    iX = 96'd0; iERROR = 32'h3F800000;
    wait_done();

    // iLOAD during a pass is ignored.
    load_w(vecs[0].w_init);
    start_pass(vecs[0], 1'b0);
    repeat (10) @(negedge clk);
    iW_INIT = 96'h12345678_9ABCDEF0_0F0F0F0F; iLOAD = 1'b1;
    @(negedge clk);
    iLOAD = 1'b0;
    wait_done();

    // iLOAD and iSTART together in IDLE: load wins, start dropped.
    @(negedge clk);
    iW_INIT = 96'h40400000_3F800000_3E000000; iLOAD = 1'b1; iSTART = 1'b1;
    @(posedge clk); #1;
    iLOAD = 1'b0; iSTART = 1'b0;
    d0 = done_seen; busy_seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (oBUSY === 1'b1) busy_seen++;
    end
    check("prio_busy_cycles", 96'(busy_seen), 96'd0);
    check("prio_done_count", 96'(done_seen - d0), 96'd0);
    check("prio_loaded", oW, 96'h40400000_3F800000_3E000000);

    // Asynchronous reset at cycle 20 of a pass.
    load_w(vecs[0].w_init);
    start_pass(vecs[0], 1'b0);
    repeat (20) @(negedge clk);
    #2;
    iRST = 1'b1;
    #1;
    check("rst_async_busy", 96'(oBUSY), 96'd0);
    check("rst_async_done", 96'(oDONE), 96'd0);
    check("rst_async_oW", oW, 96'd0);
    sb_q.delete();
    @(negedge clk);
    iRST = 1'b0;
    d0 = done_seen;
    repeat (60) @(negedge clk);
    check("rst_no_stale_done", 96'(done_seen - d0), 96'd0);
    check("rst_weights_zero", oW, 96'd0);
    // Fresh pass from zero weights.
    start_pass('{96'd0, 32'h3F000000, 32'h3E800000,
                 96'h40000000_BF800000_3F800000, 96'h3E800000_BE000000_3E000000}, 1'b0);
    wait_done();
    @(negedge clk);
    check("scoreboard_empty", 96'(sb_q.size()), 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
